// File: rtl/ps2_player_input.sv
// PS/2 keyboard receiver that decodes W/S and extended Up/Down make/break codes
// into 2-bit paddle commands for players 1 and 2.
module ps2_player_input #(
    parameter logic [31:0] TIMEOUT = 32'd60000
) (
    input  logic       clk,
    input  logic       b_rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] p1,
    output logic [1:0] p2,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned BIT_W = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [7:0] K_EXT = 8'hE0;
    localparam logic [7:0] K_BRK = 8'hF0;
    localparam logic [7:0] K_W   = 8'h1D;
    localparam logic [7:0] K_S   = 8'h1B;
    localparam logic [7:0] K_UP  = 8'h75;
    localparam logic [7:0] K_DN  = 8'h72;

    logic             clk_s1, clk_s2, clk_s3;
    logic             dat_s1, dat_s2;
    logic             fall;

    logic [1:0]       state, state_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift_q, shift_nxt;
    logic             par_q, par_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic             timeout_c;
    logic             good_c;
    logic             err_c;

    logic             ext, brk;
    logic             p1_up, p1_dn, p2_up, p2_dn;

    // Two-flop synchronisers; line idles high so reset to 1 avoids a false edge
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    // Frame FSM state register
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift_q  <= shift_nxt;
            par_q    <= par_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Next-state logic; a timeout overrides a coincident edge
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        par_nxt     = par_q;
        good_c      = 1'b0;
        err_c       = 1'b0;
        timeout_c   = (state != S_IDLE) && (idle_cnt == TIMEOUT);

        if (timeout_c) begin
            state_nxt = S_IDLE;
            err_c     = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shift_nxt   = {dat_s2, shift_q[7:1]};
                    bit_cnt_nxt = BIT_W'(bit_cnt + BIT_W'(1));
                    if (bit_cnt == BIT_W'(7)) state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = S_STOP;
                end
                default: begin
                    if (dat_s2 && (^{shift_q, par_q})) good_c = 1'b1;
                    else                                err_c  = 1'b1;
                    state_nxt = S_IDLE;
                end
            endcase
        end

        if ((state == S_IDLE) || fall || timeout_c) idle_cnt_nxt = '0;
        else                                         idle_cnt_nxt = CNT_W'(idle_cnt + CNT_W'(1));
    end

    // Registered byte output and strobes
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= good_c;
            frame_err  <= err_c;
            if (good_c) code <= shift_q;
        end
    end

    // Make/break decoder; prefixes are dropped on any framing error
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            p1_up <= 1'b0;
            p1_dn <= 1'b0;
            p2_up <= 1'b0;
            p2_dn <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (code_valid) begin
            if (code == K_EXT) begin
                ext <= 1'b1;
            end else if (code == K_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!ext && code == K_W)  p1_up <= !brk;
                if (!ext && code == K_S)  p1_dn <= !brk;
                if (ext  && code == K_UP) p2_up <= !brk;
                if (ext  && code == K_DN) p2_dn <= !brk;
            end
        end
    end

    assign p1 = {p1_up, p1_dn};
    assign p2 = {p2_up, p2_dn};

endmodule

// File: tb/tb_ps2_player_input.sv
// Bench for ps2_player_input: table of frames with a strobe scoreboard, plus
// hand sequences for latency, timeout and mid-frame reset.
module tb_ps2_player_input;

    localparam logic [31:0] TMO  = 32'd200;
    localparam int          HALF = 10;

    logic       clk = 1'b0;
    logic       b_rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] p1, p2;
    logic [7:0] code;
    logic       code_valid, frame_err;

    ps2_player_input #(.TIMEOUT(TMO)) dut (
        .clk(clk), .b_rst(b_rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .p1(p1), .p2(p2), .code(code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        logic [1:0] exp_p1;
        logic [1:0] exp_p2;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int cv_cyc = 0;
    int p1_chg_cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int cv_long = 0;
    logic [1:0] p1_prev = 2'b00;
    logic       cv_prev = 1'b0;
    logic [7:0] last_code = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (b_rst) begin
            if (code_valid && frame_err) begin
                total++;
                $display("FAIL strobe_overlap: code_valid and frame_err both high");
            end
            if (code_valid) n_valid++;
            if (frame_err) n_err++;
            if (code_valid && cv_prev) cv_long++;
            if (code_valid) cv_cyc = cyc;
            if (p1 !== p1_prev) p1_chg_cyc = cyc;
            if (code_valid || frame_err) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_strobe: cv=%0b err=%0b code=%0h", code_valid, frame_err, code);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_kind", 32'(frame_err), 32'(e.is_err));
                    if (!e.is_err) check("sb_code", 32'(code), 32'(e.code));
                end
            end
        end
        p1_prev = p1;
        cv_prev = code_valid;
    end

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        exp_t e;
        e.is_err = bad_par | bad_stop;
        e.code   = b;
        sb.push_back(e);
        send_bits(b, bad_par, bad_stop, 11);
        if (!e.is_err) last_code = b;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d events outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] ep1, input logic [1:0] ep2);
        wait_drain();
        repeat (2) @(negedge clk);
        check({tag, "_p1"}, 32'(p1), 32'(ep1));
        check({tag, "_p2"}, 32'(p2), 32'(ep2));
        check({tag, "_code"}, 32'(code), 32'(last_code));
    endtask

    initial begin
        int e0, v0;
        tbl.push_back('{8'hF0, 0, 0, 2'b10, 2'b00});
        tbl.push_back('{8'h1D, 0, 0, 2'b00, 2'b00});
        tbl.push_back('{8'h1B, 0, 0, 2'b01, 2'b00});
        tbl.push_back('{8'hE0, 0, 0, 2'b01, 2'b00});
        tbl.push_back('{8'h75, 0, 0, 2'b01, 2'b10});
        tbl.push_back('{8'hE0, 0, 0, 2'b01, 2'b10});
        tbl.push_back('{8'h72, 0, 0, 2'b01, 2'b11});
        tbl.push_back('{8'hE0, 0, 0, 2'b01, 2'b11});
        tbl.push_back('{8'hF0, 0, 0, 2'b01, 2'b11});
        tbl.push_back('{8'h75, 0, 0, 2'b01, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 2'b01, 2'b01});
        tbl.push_back('{8'h1D, 1, 0, 2'b01, 2'b01});
        tbl.push_back('{8'h1D, 0, 1, 2'b01, 2'b01});
        tbl.push_back('{8'h1D, 0, 0, 2'b11, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 2'b11, 2'b01});
        tbl.push_back('{8'h1B, 0, 0, 2'b10, 2'b01});
        tbl.push_back('{8'hF0, 0, 0, 2'b10, 2'b01});
        tbl.push_back('{8'h1D, 0, 0, 2'b00, 2'b01});

        repeat (3) @(negedge clk);
        check("rst_p1", 32'(p1), 32'd0);
        check("rst_p2", 32'(p2), 32'd0);
        check("rst_code", 32'(code), 32'd0);
        check("rst_cv", 32'(code_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        b_rst = 1'b1;
        repeat (5) @(negedge clk);

        // First W press: strobe width and latency
        send_frame(8'h1D, 0, 0);
        check_outputs("w_press", 2'b10, 2'b00);
        check("cv_one_cycle", 32'(cv_long), 32'd0);
        check("p1_after_cv", 32'(p1_chg_cyc - cv_cyc), 32'd1);
        check("p1_latency_ok", 32'((p1_chg_cyc - fall_cyc) inside {[4:5]}), 32'd1);

        // Table: one frame per row; the F0 row leaves the break prefix pending
        foreach (tbl[i]) begin
            send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
            check_outputs($sformatf("vec%0d", i), tbl[i].exp_p1, tbl[i].exp_p2);
        end

        // Truncated frame: exactly one timeout error, receiver recovers
        e0 = n_err;
        v0 = n_valid;
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.code   = 8'h00;
            sb.push_back(e);
        end
        send_bits(8'h1B, 0, 0, 5);
        repeat (int'(TMO) + 5) @(negedge clk);
        wait_drain();
        check("tmo_err_count", 32'(n_err - e0), 32'd1);
        check("tmo_no_valid", 32'(n_valid - v0), 32'd0);
        send_frame(8'h1B, 0, 0);
        check_outputs("after_tmo", 2'b01, 2'b01);

        // Release S, press W, then reset in the middle of a frame
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1B, 0, 0);
        send_frame(8'h1D, 0, 0);
        check_outputs("w_held", 2'b10, 2'b01);
        e0 = n_err;
        v0 = n_valid;
        send_bits(8'h1B, 0, 0, 4);
        @(negedge clk) b_rst = 1'b0;
        repeat (2) @(negedge clk);
        b_rst = 1'b1;
        last_code = 8'h00;
        check("mid_rst_p1", 32'(p1), 32'd0);
        check("mid_rst_p2", 32'(p2), 32'd0);
        check("mid_rst_code", 32'(code), 32'd0);
        repeat (int'(TMO) + 20) @(negedge clk);
        check("mid_rst_no_strobe", 32'((n_err - e0) + (n_valid - v0)), 32'd0);
        send_frame(8'h1D, 0, 0);
        check_outputs("post_rst", 2'b10, 2'b00);
        check("final_cv_one_cycle", 32'(cv_long), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end

endmodule
